// File: rtl/fix_to_fp_11_5_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fix_to_fp_11_5_pkg
// Purpose : Shared constants for the FloPoCo 11_5 floating-point format
//           (wE=5, wF=11): exception codes, field widths, exponent bias and
//           the encoder FSM state encoding. The greater_than decoder reuses
//           the same field constants.
// Revision: 1.0 - initial release
// ============================================================================
package fix_to_fp_11_5_pkg;

    localparam int FP_WE   = 5;
    localparam int FP_WF   = 11;
    localparam int FP_BIAS = (1 << (FP_WE - 1)) - 1;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage : fix_to_fp_11_5_pkg
`default_nettype wire

// File: rtl/fix_to_fp_11_5_fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module  : fp_round_pack
// Purpose : Combinational round-to-nearest-even and pack stage. Takes the
//           bits below the leading one of the normalised magnitude, the
//           signed biased exponent and the sign; produces the FloPoCo word.
// Ports   : mag  - normalised magnitude without its leading one
//           e    - signed biased exponent (before rounding carry)
//           sign - operand sign
//           fp   - packed {exc[1:0], sign, exponent[WE-1:0], fraction[WF-1:0]}
// Revision: 1.0 - initial release
// ============================================================================
module fp_round_pack
    import fix_to_fp_11_5_pkg::*;
#(
    parameter int width = 18,
    parameter int WE    = FP_WE,
    parameter int WF    = FP_WF,
    parameter int IN_W  = 24
) (
    input  logic                 sign,
    input  logic [IN_W-2:0]      mag,
    input  logic signed [WE+1:0] e,
    output logic [width:0]       fp
);

    localparam int GPOS = IN_W - 2 - WF;
    localparam logic signed [WE+1:0] E_MAX = (WE+2)'((1 << WE) - 1);

    logic [WF-1:0]        w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic [WF:0]          w_sum;
    logic signed [WE+1:0] w_e_adj;

    assign w_frac   = mag[IN_W-2 -: WF];
    assign w_guard  = mag[GPOS];
    assign w_sticky = |mag[GPOS-1:0];
    // Ties go to the even fraction: only round up on an exact half when LSB=1.
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);
    assign w_sum    = {1'b0, w_frac} + {{WF{1'b0}}, w_inc};
    // A carry out of the fraction means 1.111..1 rounded to 10.000..0:
    // the fraction wraps to zero (w_sum[WF-1:0]) and the exponent moves up.
    assign w_e_adj  = e + $signed({{(WE+1){1'b0}}, w_sum[WF]});

    always_comb begin
        fp = '0;
        if (w_e_adj > E_MAX) begin
            fp = {EXC_INF, sign, {(WE+WF){1'b0}}};
        end else if (w_e_adj[WE+1]) begin
            fp = {EXC_ZERO, sign, {(WE+WF){1'b0}}};
        end else begin
            fp = {EXC_NORMAL, sign, w_e_adj[WE-1:0], w_sum[WF-1:0]};
        end
    end

endmodule : fp_round_pack
`default_nettype wire

// File: rtl/fix_to_fp_11_5.sv
`default_nettype none
// ============================================================================
// Module  : fix_to_fp_11_5
// Purpose : Sequential encoder from signed fixed-point (value = in_fix /
//           2^FRAC_BITS) to the 19-bit FloPoCo 11_5 word. Normalises one bit
//           per cycle, then rounds and packs. Valid/ready on both sides.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           in_fix/in_valid/in_ready    - operand handshake
//           out_fp/out_valid/out_ready  - result handshake
// Revision: 1.0 - initial release
// ============================================================================
module fix_to_fp_11_5
    import fix_to_fp_11_5_pkg::*;
#(
    parameter int width     = 18,
    parameter int WE        = FP_WE,
    parameter int WF        = FP_WF,
    parameter int IN_W      = 24,
    parameter int FRAC_BITS = 8,
    parameter int BIAS      = FP_BIAS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_fix,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [width:0]  out_fp,
    output logic            out_valid,
    input  logic            out_ready
);

    // Exponent of a magnitude whose leading one sits at bit IN_W-1.
    localparam logic signed [WE+1:0] E_INIT = (WE+2)'(IN_W - 1 - FRAC_BITS + BIAS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_W-1:0]      r_mag;
    logic signed [WE+1:0] r_e;
    logic                 r_sign;
    logic [width:0]       r_fp;
    logic [IN_W-1:0]      w_mag_in;
    logic                 w_in_zero;
    logic [width:0]       w_fp_packed;

    // Unsigned negation: the most negative input maps to 2^(IN_W-1) exactly.
    assign w_mag_in  = in_fix[IN_W-1] ? (-in_fix) : in_fix;
    assign w_in_zero = (in_fix == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_in_zero ? ST_OUT : ST_NORM;
                end
            end
            ST_NORM: begin
                if (r_mag[IN_W-1]) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag  <= '0;
            r_e    <= '0;
            r_sign <= 1'b0;
            r_fp   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= in_fix[IN_W-1];
                        r_mag  <= w_mag_in;
                        r_e    <= E_INIT;
                        if (w_in_zero) begin
                            r_fp <= '0;
                        end
                    end
                end
                ST_NORM: begin
                    if (!r_mag[IN_W-1]) begin
                        r_mag <= {r_mag[IN_W-2:0], 1'b0};
                        r_e   <= r_e - (WE+2)'(1);
                    end
                end
                ST_ROUND: begin
                    r_fp <= w_fp_packed;
                end
                default: begin
                end
            endcase
        end
    end

    fp_round_pack #(
        .width (width),
        .WE    (WE),
        .WF    (WF),
        .IN_W  (IN_W)
    ) u_round_pack (
        .sign (r_sign),
        .mag  (r_mag[IN_W-2:0]),
        .e    (r_e),
        .fp   (w_fp_packed)
    );

    assign out_fp = r_fp;

endmodule : fix_to_fp_11_5
`default_nettype wire

// File: tb/tb_fix_to_fp_11_5.sv
`default_nettype none
// ============================================================================
// Module  : tb_fix_to_fp_11_5
// Purpose : Self-checking bench for fix_to_fp_11_5 against a value-level
//           reference model (integer arithmetic on the fixed-point value).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fix_to_fp_11_5;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_fix;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] out_fp;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fix_to_fp_11_5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_fix    (in_fix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_fp    (out_fp),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: value = x / 2^8, |value| = m * 2^(p-8) with p = leading-one
    // position; exponent = p - 8 + 15; 11-bit fraction rounded to nearest even.
    task automatic model(input logic [23:0] x, output logic [18:0] fp, output int lat);
        longint v, m, q, rem, half, e, frac, exc, s;
        int p, sh;
        v = longint'($signed(x));
        s = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        if (m == 0) begin
            fp  = '0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) p = i;
        lat = 3 + (23 - p);
        e = p - 8 + 15;
        if (p > 11) begin
            sh   = p - 11;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        end else begin
            q = m << (11 - p);
        end
        if (q == 4096) begin
            q = 2048;
            e = e + 1;
        end
        frac = q - 2048;
        if (e > 31) begin
            exc = 2; e = 0; frac = 0;
        end else if (e < 0) begin
            exc = 0; e = 0; frac = 0;
        end else begin
            exc = 1;
        end
        fp = 19'(exc * 131072 + s * 65536 + e * 2048 + frac);
    endtask

    // Drives one operand and collects the result and its latency.
    task automatic do_conv(input logic [23:0] x, output logic [18:0] fp,
                           output int lat, output bit tmo);
        int j;
        tmo = 1'b0;
        j = 0;
        while (!in_ready && j < 200) begin
            @(posedge clk); #1; j++;
        end
        in_fix   = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        j = 0;
        while (!out_valid && j < 200) begin
            @(posedge clk); #1; j++;
        end
        if (!out_valid) tmo = 1'b1;
        lat = j + 1;
        fp  = out_fp;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_fix = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_fp !== 19'h0) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b out_fp=%h, required 0 1 00000",
                     out_valid, in_ready, out_fp);
        end
    endtask

    task automatic test_directed();
        logic [23:0] vec [5] = '{24'h000100, 24'hFFFE80, 24'h000000, 24'h800000, 24'h7FFC00};
        logic [18:0] req [5] = '{19'h27800, 19'h37C00, 19'h00000, 19'h3F000, 19'h2F000};
        int          rlat[5] = '{18, 18, 1, 3, 4};
        logic [18:0] fp;
        int lat;
        bit tmo;
        for (int i = 0; i < 5; i++) begin
            do_conv(vec[i], fp, lat, tmo);
            checks++;
            if (tmo || fp !== req[i] || lat != rlat[i]) begin
                errors++;
                $display("FAIL directed in=%h: out_fp=%h lat=%0d tmo=%b, required %h lat=%0d",
                         vec[i], fp, lat, tmo, req[i], rlat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] x;
        logic [18:0] fp, exp_fp;
        int lat, exp_lat;
        bit tmo;
        for (int i = 0; i < 40; i++) begin
            x = 24'($urandom) >> $urandom_range(0, 23);
            if ($urandom_range(0, 1) == 1) x = -x;
            model(x, exp_fp, exp_lat);
            do_conv(x, fp, lat, tmo);
            checks++;
            if (tmo || fp !== exp_fp || lat != exp_lat) begin
                errors++;
                $display("FAIL random in=%h: out_fp=%h lat=%0d tmo=%b, required %h lat=%0d",
                         x, fp, lat, tmo, exp_fp, exp_lat);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_handshake: in_ready=%b out_valid=%b, required 1 0",
                         in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] a, b;
        logic [18:0] exp_a, exp_b;
        int lat, j;
        a = 24'h012345;
        b = 24'hFFF123;
        model(a, exp_a, lat);
        model(b, exp_b, lat);
        in_fix = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_fix = b;                        // held high while busy: must be ignored
        j = 0;
        while (!out_valid && j < 200) begin
            @(posedge clk); #1; j++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_fp !== exp_a) begin
                errors++;
                $display("FAIL backpressure cyc%0d: out_valid=%b in_ready=%b out_fp=%h, required 1 0 %h",
                         c, out_valid, in_ready, out_fp, exp_a);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;                // handshake cycle: b not captured
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;                // b captured now
        in_valid = 1'b0;
        j = 0;
        while (!out_valid && j < 200) begin
            @(posedge clk); #1; j++;
        end
        checks++;
        if (out_fp !== exp_b || !out_valid) begin
            errors++;
            $display("FAIL bp_next_operand: out_fp=%h valid=%b, required %h", out_fp, out_valid, exp_b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_norm();
        logic [18:0] fp;
        int lat;
        bit tmo;
        in_fix = 24'h000100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_fp !== 19'h0) begin
            errors++;
            $display("FAIL reset_mid_norm: out_valid=%b in_ready=%b out_fp=%h, required 0 1 00000",
                     out_valid, in_ready, out_fp);
        end
        do_conv(24'h000100, fp, lat, tmo);
        checks++;
        if (tmo || fp !== 19'h27800 || lat != 18) begin
            errors++;
            $display("FAIL after_reset_conv: out_fp=%h lat=%0d, required 27800 lat=18", fp, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_norm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fix_to_fp_11_5
`default_nettype wire
